// File: rtl/lsu_pkg.sv
// Shared types for the load/store bus bridge: access unit encoding,
// bridge FSM states and the registered response payload.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    UNIT_BYTE = 2'd0,
    UNIT_HALF = 2'd1,
    UNIT_WORD = 2'd2
  } mem_unit_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic            fault;
    logic            misaligned;
    logic            timeout;
  } rsp_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane helper (byte offset 0 lives in bits 31:24).
//   unit_i/offset_i/signed_i : access shape
//   raw_i                    : word read from the device
//   wd_i                     : right-aligned store data
//   ld_data_o                : extracted and extended load data
//   st_word_o                : raw_i with the addressed lanes replaced by wd_i
//   misaligned_o             : half at odd offset, word at non-zero offset
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      unit_i,
  input  logic [1:0]      offset_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] raw_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] ld_data_o,
  output logic [XLEN-1:0] st_word_o,
  output logic            misaligned_o
);

  logic [4:0]  byte_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // (3 - offset) * 8: offset 0 is the most significant byte
    byte_sh      = {~offset_i, 3'b000};
    byte_v       = 8'(raw_i >> byte_sh);
    half_v       = offset_i[1] ? raw_i[15:0] : raw_i[31:16];
    ld_data_o    = '0;
    st_word_o    = raw_i;
    misaligned_o = 1'b0;
    case (unit_i)
      UNIT_BYTE: begin
        ld_data_o = {{24{signed_i & byte_v[7]}}, byte_v};
        st_word_o = (raw_i & ~(32'h0000_00FF << byte_sh)) | ({24'h0, wd_i[7:0]} << byte_sh);
      end
      UNIT_HALF: begin
        ld_data_o    = {{16{signed_i & half_v[15]}}, half_v};
        misaligned_o = offset_i[0];
        st_word_o    = offset_i[1] ? {raw_i[31:16], wd_i[15:0]} : {wd_i[15:0], raw_i[15:0]};
      end
      UNIT_WORD: begin
        ld_data_o    = raw_i;
        misaligned_o = |offset_i;
        st_word_o    = wd_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core memory stage and DEVICE_COUNT
// memory-mapped devices.
//   req_*  : core request (valid/ready), accepted only in IDLE
//   rsp_*  : registered response, held until rsp_ready
//   dev_*  : per-device re/we strobes with word address, broadcast write
//            word, read data/ack back, and the address map / writability
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned DEVICE_COUNT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [1:0]                       req_unit,
  input  logic                             req_signed,
  input  logic [31:0]                      req_addr,
  input  logic [31:0]                      req_wd,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_rd,
  output logic                             rsp_access_fault,
  output logic                             rsp_addr_misaligned,
  output logic                             rsp_timeout,
  output logic [DEVICE_COUNT-1:0][31:2]    dev_addr,
  output logic [DEVICE_COUNT-1:0]          dev_re,
  output logic [DEVICE_COUNT-1:0]          dev_we,
  output logic [DEVICE_COUNT-1:0][31:0]    dev_wd,
  input  logic [DEVICE_COUNT-1:0][31:0]    dev_rd,
  input  logic [DEVICE_COUNT-1:0]          dev_ack,
  input  logic [DEVICE_COUNT-1:0]          dev_rw,
  input  logic [DEVICE_COUNT-1:0][31:0]    dev_addr_start,
  input  logic [DEVICE_COUNT-1:0][31:0]    dev_addr_end
);

  localparam int unsigned IDX_W = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e                    state_q, state_d;
  logic                          we_q, we_d, sgn_q, sgn_d;
  logic [1:0]                    unit_q, unit_d;
  logic [31:0]                   wd_q, wd_d, loc_q, loc_d, wword_q, wword_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  rsp_t                          rsp_q, rsp_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          req_ready_q, req_ready_d;
  logic [DEVICE_COUNT-1:0]       dev_re_q, dev_re_d, dev_we_q, dev_we_d;
  logic [DEVICE_COUNT-1:0][31:2] dev_addr_q, dev_addr_d;

  logic             hit, req_fault, wait_expired;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      hit_loc;
  logic [1:0]       la_unit, la_off;
  logic [31:0]      la_ld, la_st;
  logic             la_mis;

  // Address decode: the highest-index device whose inclusive range matches wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEVICE_COUNT; i++) begin
      if (req_addr >= dev_addr_start[i] && req_addr <= dev_addr_end[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_loc      = hit ? (req_addr - dev_addr_start[hit_idx]) : req_addr;
  assign req_fault    = !hit || (req_unit == 2'b11) || (req_we && !dev_rw[hit_idx]);
  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // One lane helper: checks the incoming request in IDLE, shapes data later
  assign la_unit = (state_q == ST_IDLE) ? req_unit    : unit_q;
  assign la_off  = (state_q == ST_IDLE) ? hit_loc[1:0] : loc_q[1:0];

  lsu_lane_align u_lane (
    .unit_i       (la_unit),
    .offset_i     (la_off),
    .signed_i     (sgn_q),
    .raw_i        (dev_rd[idx_q]),
    .wd_i         (wd_q),
    .ld_data_o    (la_ld),
    .st_word_o    (la_st),
    .misaligned_o (la_mis)
  );

  // Next state, latched request fields and next registered outputs
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    unit_d     = unit_q;
    sgn_d      = sgn_q;
    wd_d       = wd_q;
    loc_d      = loc_q;
    idx_d      = idx_q;
    wword_d    = wword_q;
    cnt_d      = cnt_q;
    rsp_d      = rsp_q;
    dev_re_d   = '0;
    dev_we_d   = '0;
    dev_addr_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          unit_d  = req_unit;
          sgn_d   = req_signed;
          wd_d    = req_wd;
          idx_d   = hit_idx;
          loc_d   = hit_loc;
          wword_d = req_wd;
          cnt_d   = '0;
          if (req_fault || la_mis) begin
            state_d          = ST_RESP;
            rsp_d            = '0;
            rsp_d.fault      = req_fault;
            rsp_d.misaligned = la_mis;
          end else if (!req_we || req_unit != UNIT_WORD) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (dev_ack[idx_q]) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = ST_WRITE;
            wword_d = la_st;
          end else begin
            state_d  = ST_RESP;
            rsp_d    = '0;
            rsp_d.rd = la_ld;
          end
        end else if (wait_expired) begin
          state_d       = ST_RESP;
          rsp_d         = '0;
          rsp_d.fault   = 1'b1;
          rsp_d.timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (dev_ack[idx_q]) begin
          state_d = ST_RESP;
          rsp_d   = '0;
        end else if (wait_expired) begin
          state_d       = ST_RESP;
          rsp_d         = '0;
          rsp_d.fault   = 1'b1;
          rsp_d.timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rsp_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes are registered images of the state being entered
    if (state_d == ST_READ) begin
      dev_re_d[idx_d]   = 1'b1;
      dev_addr_d[idx_d] = loc_d[31:2];
    end
    if (state_d == ST_WRITE) begin
      dev_we_d[idx_d]   = 1'b1;
      dev_addr_d[idx_d] = loc_d[31:2];
    end
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      unit_q      <= '0;
      sgn_q       <= 1'b0;
      wd_q        <= '0;
      loc_q       <= '0;
      idx_q       <= '0;
      wword_q     <= '0;
      cnt_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      dev_re_q    <= '0;
      dev_we_q    <= '0;
      dev_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      unit_q      <= unit_d;
      sgn_q       <= sgn_d;
      wd_q        <= wd_d;
      loc_q       <= loc_d;
      idx_q       <= idx_d;
      wword_q     <= wword_d;
      cnt_q       <= cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      dev_re_q    <= dev_re_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
    end
  end

  assign req_ready           = req_ready_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rd              = rsp_q.rd;
  assign rsp_access_fault    = rsp_q.fault;
  assign rsp_addr_misaligned = rsp_q.misaligned;
  assign rsp_timeout         = rsp_q.timeout;
  assign dev_re              = dev_re_q;
  assign dev_we              = dev_we_q;
  assign dev_addr            = dev_addr_q;
  assign dev_wd              = {DEVICE_COUNT{wword_q}};

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed vector table, hand
// sequences for overlap/back-pressure/reset, and randomized traffic
// against a behavioural model with a word-addressed device memory.
module tb_lsu_bus_bridge;

  localparam int ND = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, req_valid, req_ready, req_we, req_signed;
  logic [1:0]           req_unit;
  logic [31:0]          req_addr, req_wd;
  logic                 rsp_valid, rsp_ready, rsp_access_fault, rsp_addr_misaligned, rsp_timeout;
  logic [31:0]          rsp_rd;
  logic [ND-1:0][31:2]  dev_addr;
  logic [ND-1:0]        dev_re, dev_we, dev_ack, dev_rw;
  logic [ND-1:0][31:0]  dev_wd, dev_rd, dev_addr_start, dev_addr_end;

  lsu_bus_bridge #(.DEVICE_COUNT(ND), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_unit(req_unit),
    .req_signed(req_signed), .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_access_fault(rsp_access_fault), .rsp_addr_misaligned(rsp_addr_misaligned),
    .rsp_timeout(rsp_timeout),
    .dev_addr(dev_addr), .dev_re(dev_re), .dev_we(dev_we), .dev_wd(dev_wd),
    .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_rw(dev_rw),
    .dev_addr_start(dev_addr_start), .dev_addr_end(dev_addr_end)
  );

  typedef struct {
    logic [31:0] rd; bit fault, mis, to; int lat, re, wc, dev;
    logic [31:0] loc; bit wr; logic [31:0] wword;
  } exp_t;

  typedef struct {
    logic [31:0] rd; bit fault, mis, to; int lat, re, wc, bad;
    bit wrote; logic [31:0] wword; bit stable, hs;
  } got_t;

  typedef struct {
    bit we; logic [1:0] unit; bit sgn; logic [31:0] addr, wd, pre;
    int dr, dw, hold; logic [31:0] rd; bit ef, em, et; int lat; logic [31:0] wword;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mem [longint];
  vec_t vt [16];

  function automatic longint mkey(int d, logic [29:0] w);
    return longint'(d) * 64'h1_0000_0000 + longint'(w);
  endfunction

  function automatic logic [31:0] mem_get(int d, logic [29:0] w);
    if (mem.exists(mkey(d, w))) return mem[mkey(d, w)];
    return 32'hA5C3_0000 ^ {2'b00, w} ^ 32'(d * 32'h0101_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: decode, error rules, phase lengths and lane arithmetic
  function automatic exp_t model(bit we, logic [1:0] unit, bit sgn, logic [31:0] addr,
                                 logic [31:0] wd, int dr, int dw);
    exp_t e; int dev; int off, nb, sh; logic [31:0] word, mask, lane;
    e = '{default: 0}; e.lat = 1; e.dev = -1; dev = -1;
    for (int i = 0; i < ND; i++)
      if (addr >= dev_addr_start[i] && addr <= dev_addr_end[i]) dev = i;
    e.loc   = (dev >= 0) ? addr - dev_addr_start[dev] : addr;
    off     = int'(e.loc[1:0]);
    e.mis   = (unit == 2'd1 && (off % 2) != 0) || (unit == 2'd2 && off != 0);
    e.fault = (dev < 0) || (unit == 2'd3) || (we && !dev_rw[dev]);
    if (e.fault || e.mis) return e;
    e.dev = dev;
    nb    = (unit == 2'd0) ? 1 : (unit == 2'd1) ? 2 : 4;
    sh    = 8 * (4 - off - nb);
    mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    if (!we || nb < 4) begin
      if (dr >= TO) begin e.re = TO; e.lat += TO; e.fault = 1; e.to = 1; return e; end
      e.re = dr + 1; e.lat += dr + 1;
    end
    word = mem_get(dev, e.loc[31:2]);
    if (!we) begin
      lane = (word >> sh) & mask;
      if (sgn && nb < 4 && lane[8*nb-1]) lane = lane | ~mask;
      e.rd = lane;
      return e;
    end
    if (dw >= TO) begin e.wc = TO; e.lat += TO; e.fault = 1; e.to = 1; return e; end
    e.wc = dw + 1; e.lat += dw + 1; e.wr = 1;
    e.wword = (word & ~(mask << sh)) | ((wd & mask) << sh);
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; dev_ack = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request and plays the addressed device, recording what the DUT did
  task automatic do_txn(input bit we, input logic [1:0] unit, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int dr, input int dw, input int hold, input bit noise,
                        input exp_t e, output got_t g);
    int kind, prev, waitc, sel, nsel;
    logic [34:0] snap;
    g = '{default: 0}; g.lat = -1; g.stable = 1; g.hs = 1;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_unit = unit; req_signed = sgn;
    req_addr = addr; req_wd = wd;
    if (!req_ready) g.bad++;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wd = $urandom;
    prev = 0; waitc = 0;
    for (int c = 1; c <= 60; c++) begin
      dev_ack = '0;
      if (rsp_valid) begin g.lat = c; break; end
      nsel = 0; sel = -1; kind = 0;
      for (int i = 0; i < ND; i++) begin
        if (dev_re[i] || dev_we[i]) begin
          nsel++; sel = i; kind = dev_we[i] ? 2 : 1;
          if (dev_re[i] && dev_we[i]) g.bad++;
        end else if (dev_addr[i] != '0) g.bad++;
      end
      if (nsel > 1 || (nsel == 1 && (sel != e.dev || dev_addr[sel] != e.loc[31:2]))) g.bad++;
      if (kind != prev) waitc = 0;
      prev = kind;
      if (kind == 1) g.re++;
      if (kind == 2) g.wc++;
      if (noise)
        for (int i = 0; i < ND; i++)
          if (i != sel) begin dev_ack[i] = 1'($urandom_range(0, 1)); dev_rd[i] = $urandom; end
      if (kind != 0 && waitc == ((kind == 1) ? dr : dw)) begin
        dev_ack[sel] = 1'b1;
        if (kind == 1) dev_rd[sel] = mem_get(sel, dev_addr[sel]);
        else begin g.wrote = 1; g.wword = dev_wd[sel]; end
      end
      waitc++;
      @(posedge clk); @(negedge clk);
    end
    dev_ack = '0;
    if (g.lat < 0) begin
      do_reset();
      return;
    end
    g.rd = rsp_rd; g.fault = rsp_access_fault; g.mis = rsp_addr_misaligned; g.to = rsp_timeout;
    snap = {rsp_rd, rsp_access_fault, rsp_addr_misaligned, rsp_timeout};
    if (req_ready) g.stable = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (!rsp_valid || req_ready ||
          snap != {rsp_rd, rsp_access_fault, rsp_addr_misaligned, rsp_timeout}) g.stable = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    if (rsp_valid || !req_ready) g.hs = 0;
  endtask

  task automatic run_check(input string t, input exp_t e, input got_t g);
    chk({t, "/rd"}, g.rd, e.rd);
    chk({t, "/fault"}, 32'(g.fault), 32'(e.fault));
    chk({t, "/misaligned"}, 32'(g.mis), 32'(e.mis));
    chk({t, "/timeout"}, 32'(g.to), 32'(e.to));
    chk({t, "/latency"}, g.lat, e.lat);
    chk({t, "/re_cycles"}, g.re, e.re);
    chk({t, "/we_cycles"}, g.wc, e.wc);
    chk({t, "/strobe_errs"}, g.bad, 0);
    chk({t, "/rsp_stable"}, 32'(g.stable), 32'd1);
    chk({t, "/handshake"}, 32'(g.hs), 32'd1);
    if (e.wr) begin
      chk({t, "/wrote"}, 32'(g.wrote), 32'd1);
      chk({t, "/wword"}, g.wword, e.wword);
      mem[mkey(e.dev, e.loc[31:2])] = e.wword;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v; exp_t e; got_t g;
    v = vt[i];
    e = model(v.we, v.unit, v.sgn, v.addr, v.wd, v.dr, v.dw);
    if (e.dev >= 0) mem[mkey(e.dev, e.loc[31:2])] = v.pre;
    e = model(v.we, v.unit, v.sgn, v.addr, v.wd, v.dr, v.dw);
    e.rd = v.rd; e.fault = v.ef; e.mis = v.em; e.to = v.et; e.lat = v.lat;
    if (e.wr) e.wword = v.wword;
    do_txn(v.we, v.unit, v.sgn, v.addr, v.wd, v.dr, v.dw, v.hold, 1'b0, e, g);
    run_check($sformatf("vec%0d", i), e, g);
  endtask

  task automatic set_map(input bit all4);
    dev_addr_start[0] = 32'h1000; dev_addr_end[0] = 32'h1FFF; dev_rw[0] = 1'b1;
    dev_addr_start[1] = 32'h2000; dev_addr_end[1] = 32'h20FF; dev_rw[1] = 1'b0;
    dev_addr_start[2] = all4 ? 32'h4000 : 32'hFFFF_FFFF; dev_addr_end[2] = all4 ? 32'h40FF : 32'h0;
    dev_addr_start[3] = all4 ? 32'h4080 : 32'hFFFF_FFFF; dev_addr_end[3] = all4 ? 32'h417F : 32'h0;
    dev_rw[2] = 1'b1; dev_rw[3] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e; got_t g;
    bit we, sgn; logic [1:0] unit; logic [31:0] addr, wd; int dr, dw, r;
    // we unit sgn addr wd pre dr dw hold | rd fault mis to lat wword
    vt[0]  = '{0, 0, 1, 32'h1001, 0, 32'h12F4_5678, 0, 0, 0, 32'hFFFF_FFF4, 0, 0, 0, 2, 0};
    vt[1]  = '{0, 0, 0, 32'h1001, 0, 32'h12F4_5678, 0, 0, 0, 32'h0000_00F4, 0, 0, 0, 2, 0};
    vt[2]  = '{1, 1, 0, 32'h1002, 32'hABCD, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 0, 3, 32'h1122_ABCD};
    vt[3]  = '{1, 2, 0, 32'h2000, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[4]  = '{0, 2, 0, 32'h1002, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    vt[5]  = '{0, 2, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[6]  = '{0, 2, 0, 32'h1000, 0, 32'hDEAD_BEEF, 99, 0, 0, 0, 1, 0, 1, 17, 0};
    vt[7]  = '{0, 1, 1, 32'h1002, 0, 32'h1234_8001, 0, 0, 0, 32'hFFFF_8001, 0, 0, 0, 2, 0};
    vt[8]  = '{1, 0, 0, 32'h1003, 32'hFFFF_FF55, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0, 0, 3, 32'hAABB_CC55};
    vt[9]  = '{0, 3, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    vt[10] = '{0, 2, 0, 32'h1004, 0, 32'hCAFE_BABE, 3, 0, 0, 32'hCAFE_BABE, 0, 0, 0, 5, 0};
    vt[11] = '{0, 0, 0, 32'h2002, 0, 32'h0011_2233, 0, 0, 0, 32'h0000_0022, 0, 0, 0, 2, 0};
    vt[12] = '{1, 1, 0, 32'h1001, 32'h1111, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    vt[13] = '{0, 2, 1, 32'h1008, 0, 32'h8000_0001, 15, 0, 0, 32'h8000_0001, 0, 0, 0, 17, 0};
    vt[14] = '{1, 0, 0, 32'h1000, 32'h7E, 32'h0102_0304, 1, 2, 0, 0, 0, 0, 0, 6, 32'h7E02_0304};
    vt[15] = '{0, 1, 0, 32'h1006, 0, 32'h1234_ABCD, 0, 0, 0, 32'h0000_ABCD, 0, 0, 0, 2, 0};

    req_we = 0; req_unit = 0; req_signed = 0; req_addr = 0; req_wd = 0; dev_rd = '0;
    set_map(1'b0);
    do_reset();

    // Reset state
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_flags", {rsp_rd[28:0], rsp_access_fault, rsp_addr_misaligned, rsp_timeout}, 32'd0);
    chk("reset/strobes", 32'({dev_re, dev_we}), 32'd0);
    chk("reset/dev_addr", 32'(|dev_addr), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Overlapping ranges with response back-pressure
    dev_addr_start[1] = 32'h1000; dev_addr_end[1] = 32'h10FF;
    mem[mkey(1, 30'h1)] = 32'h0BAD_F00D;
    e = model(0, 2'd2, 0, 32'h1004, 0, 0, 0);
    chk("overlap/dev", e.dev, 1);
    chk("overlap/loc", e.loc, 32'h4);
    do_txn(0, 2'd2, 0, 32'h1004, 0, 0, 0, 5, 1'b0, e, g);
    run_check("overlap", e, g);
    set_map(1'b0);

    // Reset dropped mid-READ
    req_valid = 1'b1; req_we = 0; req_unit = 2'd2; req_addr = 32'h1000;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midreset/re_before", 32'(dev_re[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("midreset/re_after", 32'(dev_re), 32'd0);
    chk("midreset/req_ready", 32'(req_ready), 32'd1);
    chk("midreset/rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("midreset/no_rsp", 32'(rsp_valid), 32'd0);
    run_vec(10);

    // Randomized traffic with noise acks on unselected devices
    set_map(1'b1);
    for (int n = 0; n < 150; n++) begin
      r    = int'($urandom_range(0, 7));
      unit = (r == 0) ? 2'd3 : 2'(r % 3);
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: addr = 32'h1000; 1: addr = 32'h2000; 2: addr = 32'h4000;
        3: addr = 32'h4080; default: addr = 32'h3000;
      endcase
      addr = addr + $urandom_range(0, 32'h1FF);
      wd = $urandom;
      dr = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      e = model(we, unit, sgn, addr, wd, dr, dw);
      do_txn(we, unit, sgn, addr, wd, dr, dw, int'($urandom_range(0, 2)), 1'b1, e, g);
      run_check($sformatf("rnd%0d", n), e, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Sequential successor to the combinational memory-access decoder: a load/store bridge between the core's memory stage and DEVICE_COUNT memory-mapped devices.
- Uses a valid/ready request–response handshake toward the core and a re/we + ack handshake toward the devices, so devices may take several cycles to respond.
- Adds sign extension, read-modify-write for sub-word stores, per-access timeout and back-pressure.
- Keeps the existing address-map inputs and byte-lane convention: byte offset 0 sits in bits 31:24.

Parameters:
- DEVICE_COUNT, 4, number of device ports (≥1).
- TIMEOUT_CYCLES, 16, cycles a device phase may wait for dev_ack before aborting (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_unit  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loaded byte/half.
- req_addr  in  32  byte address.
- req_wd  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  core accepts response.
- rsp_rd  out  32  load data, extended; 0 for stores and errors.
- rsp_access_fault  out  1  unmapped, read-only store, illegal unit, or timeout.
- rsp_addr_misaligned  out  1  half with local[0]=1; word with local[1:0]≠0.
- rsp_timeout  out  1  device did not ack in time (implies rsp_access_fault).
- dev_addr  out  [DEVICE_COUNT][31:2]  word address local to the device.
- dev_re  out  [DEVICE_COUNT] 1  read strobe.
- dev_we  out  [DEVICE_COUNT] 1  write strobe.
- dev_wd  out  [DEVICE_COUNT] 32  full write word.
- dev_rd  in  [DEVICE_COUNT] 32  read word, valid when dev_ack is high.
- dev_ack  in  [DEVICE_COUNT] 1  access complete.
- dev_rw  in  [DEVICE_COUNT] 1  device writable.
- dev_addr_start  in  [DEVICE_COUNT] 32  inclusive base address.
- dev_addr_end  in  [DEVICE_COUNT] 32  inclusive limit address.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state ← IDLE; timeout counter ← 0.
  - req_ready=1; rsp_valid=0; rsp_* =0; every dev_re/dev_we=0; every dev_addr=0.
  - Any in-flight transaction is dropped with no response.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE, request accepted (req_valid && req_ready):
  - Latch we, unit, signed, wd, chosen device index, local address = addr − dev_addr_start[idx].
  - Decode: highest-index device whose inclusive range contains addr wins.
  - Errors: no match → fault; unit 11 → fault; store to dev_rw=0 → fault; misalignment checked on the local address.
  - Any error → RESP with the matching flags; no device strobe is ever raised.
  - Otherwise: load → READ; word store → WRITE; byte/half store → READ (read-modify-write).
- READ:
  - dev_re[idx]=1 and dev_addr[idx]=local[31:2] every cycle until ack.
  - On dev_ack[idx], capture dev_rd[idx].
  - Load → RESP with the extracted and extended data.
  - RMW store → WRITE with merged word: captured word with the addressed lanes replaced by wd[7:0] or wd[15:0].
- WRITE:
  - dev_we[idx]=1, dev_wd=write word, dev_addr set, until dev_ack[idx] → RESP.
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each cycle without ack.
  - If the count reaches TIMEOUT_CYCLES−1 with no ack → RESP with fault=1, timeout=1, rd=0; strobes drop next cycle.
  - An ack arriving in that same cycle wins.
- RESP:
  - rsp_valid=1 with stable payload; return to IDLE when rsp_ready=1.
  - req_ready is 0 here; there is no request/response overlap.
- Lane map:
  - Byte offsets 0/1/2/3 → bits [31:24]/[23:16]/[15:8]/[7:0].
  - Half offsets 0/2 → [31:16]/[15:0].
- Extension: zero-extend unless req_signed=1 and unit is byte/half.
- Latency: zero-wait device, load, accept at cycle T → rsp_valid at T+2. RMW store → T+3. Error → T+1.
- Non-selected devices: strobes 0, dev_addr 0. dev_wd is broadcast to all devices.
- Any dev_ack from a non-selected device, or while not in READ/WRITE, is ignored.

Decomposition:
- Package lsu_pkg:
  - mem_unit_e (UNIT_BYTE=0, UNIT_HALF=1, UNIT_WORD=2).
  - lsu_state_e.
  - rsp_t struct (rd, fault, misaligned, timeout).
- Sub-module lsu_lane_align (combinational):
  - Inputs: unit, offset, signed, raw word, store data.
  - Outputs: extended load data, merged store word, misaligned flag.

Test Plan:
- Common map: dev0 at 0x1000–0x1FFF rw; dev1 at 0x2000–0x20FF ro.
- Signed byte load at 0x1001, dev_rd=0x12F45678, ack in the first READ cycle → dev_addr[0]=0x000, rsp_rd=0xFFFFFFF4 at T+2; unsigned → 0x000000F4.
- Half store 0x1002 wd=0xABCD, old word 0x11223344 → one READ, then WRITE with dev_wd=0x1122ABCD; rsp_valid at T+3, no errors.
- Word store 0x2000 → rsp_access_fault=1, dev_we never asserted; word load 0x1002 → rsp_addr_misaligned=1, no dev_re; load 0x3000 → fault.
- Load at 0x1000 with dev_ack held low → dev_re high for exactly 16 cycles, then rsp fault=1, timeout=1, rd=0.
- Overlap: make dev1 range 0x1000–0x10FF; load 0x1004 → dev1 selected with local address 0x4. Also hold rsp_ready=0 for 5 cycles → payload stable, req_ready=0 throughout.
- Drive rst_n=0 for one cycle mid-READ → next cycle dev_re=0, req_ready=1, no rsp_valid; the following request completes normally.
